// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: combinational D-stage decode feeding E/M/W control
// registers, with a busy counter that holds back mult/div while the unit works.
module pipelined_control_unit #(
  parameter int ALU_W      = 3,
  parameter int MD_LATENCY = 4,
  parameter int EN_MULDIV  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             StallIn,
  input  logic             FlushE,
  output logic             BranchD,
  output logic             IllegalD,
  output logic             StallMD,
  output logic             MdStartE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [ALU_W-1:0] ALUControlE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegW
);

  typedef struct packed {
    logic             regWrite;
    logic             memtoReg;
    logic             memWrite;
    logic             aluSrc;
    logic             regDst;
    logic             mdStart;
    logic [ALU_W-1:0] aluCtl;
  } ctrlT;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic memWrite;
  } memCtrlT;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
  } wbCtrlT;

  localparam logic [ALU_W-1:0] AluAnd = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] AluOr  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] AluAdd = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] AluSub = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] AluSlt = ALU_W'(3'b111);
  localparam logic [3:0]       MdLoad = 4'(MD_LATENCY);

  function automatic ctrlT mk(input logic rw, mtr, mw, as, rd, md,
                              input logic [ALU_W-1:0] alu);
    mk = '{regWrite: rw, memtoReg: mtr, memWrite: mw, aluSrc: as,
           regDst: rd, mdStart: md, aluCtl: alu};
  endfunction

  ctrlT       ctrlD, ctrlENext, ctrlE;
  memCtrlT    ctrlM;
  wbCtrlT     ctrlW;
  logic [3:0] mdCnt;

  always_comb begin
    ctrlD    = '0;
    BranchD  = 1'b0;
    IllegalD = 1'b0;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100000: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AluAdd);
          6'b100010: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AluSub);
          6'b100100: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AluAnd);
          6'b100101: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AluOr);
          6'b101010: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AluSlt);
          6'b011000, 6'b011010: begin
            if (EN_MULDIV != 0) ctrlD = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AluAnd);
            else                IllegalD = 1'b1;
          end
          default: IllegalD = 1'b1;
        endcase
      end
      6'b001000: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AluAdd);
      6'b001001: ctrlD = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AluSub);
      6'b000100: begin
        ctrlD   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AluSub);
        BranchD = 1'b1;
      end
      6'b100011: ctrlD = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, AluAdd);
      6'b101011: ctrlD = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AluAdd);
      default:   IllegalD = 1'b1;
    endcase
  end

  // Only a mult/div waits on the busy unit; everything else flows past it.
  assign StallMD   = (mdCnt != 4'd0) && ctrlD.mdStart;
  assign ctrlENext = (FlushE || StallIn || StallMD) ? '0 : ctrlD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlE <= '0;
      ctrlM <= '0;
      ctrlW <= '0;
      mdCnt <= 4'd0;
    end else begin
      ctrlE <= ctrlENext;
      ctrlM <= '{regWrite: ctrlE.regWrite, memtoReg: ctrlE.memtoReg,
                 memWrite: ctrlE.memWrite};
      ctrlW <= '{regWrite: ctrlM.regWrite, memtoReg: ctrlM.memtoReg};
      // A bubbled mult/div never reaches E, so it never arms the counter.
      if (ctrlENext.mdStart)  mdCnt <= MdLoad;
      else if (mdCnt != 4'd0) mdCnt <= mdCnt - 4'd1;
    end
  end

  assign MdStartE    = ctrlE.mdStart;
  assign RegWriteE   = ctrlE.regWrite;
  assign MemtoRegE   = ctrlE.memtoReg;
  assign MemWriteE   = ctrlE.memWrite;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign RegDstE     = ctrlE.regDst;
  assign ALUControlE = ctrlE.aluCtl;
  assign RegWriteM   = ctrlM.regWrite;
  assign MemtoRegM   = ctrlM.memtoReg;
  assign MemWriteM   = ctrlM.memWrite;
  assign RegWriteW   = ctrlW.regWrite;
  assign MemtoRegW   = ctrlW.memtoReg;

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter ALU_W, default 3: ALU control code width (>=3; codes zero-extended).
REQ-002 SHALL have parameter MD_LATENCY, default 4: mult/div unit busy cycles (1..15).
REQ-003 SHALL have parameter EN_MULDIV, default 1: 1 decodes mult/div, 0 treats them as illegal.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, ports named:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  Op  in  6  D-stage opcode
  Funct  in  6  D-stage function field
  StallIn  in  1  external hazard stall (D held, E bubbled)
  FlushE  in  1  clear E-stage bundle next edge
  BranchD  out  1  combinational, BEQZ in D
  IllegalD  out  1  combinational, undecodable Op/Funct
  StallMD  out  1  combinational, mult/div structural stall
  MdStartE  out  1  mult/div start pulse in E
  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  E-stage control
  ALUControlE  out  ALU_W  E-stage ALU code
  RegWriteM, MemtoRegM, MemWriteM  out  1 each  M-stage control
  RegWriteW, MemtoRegW  out  1 each  W-stage control

Function
REQ-005 SHALL decode D combinationally: R-type Op=000000 -> RegWrite=1, RegDst=1, ALUSrc=0; Funct 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111.
REQ-006 SHALL decode ADDI 001000 -> RegWrite, ALUSrc, ALU 010; SUBI 001001 -> RegWrite, ALUSrc, ALU 110.
REQ-007 SHALL decode BEQZ 000100 -> Branch=1, ALU 110, no RegWrite/MemWrite; LW 100011 -> RegWrite, MemtoReg, ALUSrc, ALU 010; SW 101011 -> MemWrite, ALUSrc, ALU 010.
REQ-008 SHALL decode Funct 011000 (mult)/011010 (div) with Op=0 and EN_MULDIV=1 as MulDiv: all write/mem controls 0, MdStart=1.
REQ-009 SHALL output all-zero bundle and IllegalD=1 for any other Op/Funct (incl. MulDiv when EN_MULDIV=0).
REQ-010 SHALL register D bundle into E each edge, 1-cycle latency; E->M and M->W likewise each edge, never stalled.
REQ-011 SHALL load all-zero bundle into E (bubble) when FlushE, StallIn or StallMD is 1 at the edge; flush wins over any simultaneous event.
REQ-012 SHALL hold busy counter: loaded with MD_LATENCY on the edge MdStart enters E; decrements by 1 each later edge; saturates at 0.
REQ-013 SHALL assert StallMD = (counter != 0) AND D decodes MulDiv; non-MulDiv instructions never stall on counter.
REQ-014 SHALL, when MulDiv is bubbled (flush/stall), not load the counter; MulDiv retries when D is released.
REQ-015 SHALL permit back-to-back issue: MulDiv in D when counter==0 (incl. the cycle it reaches 0) enters E at the next edge.

Reset
REQ-016 SHALL, on rst_n=0, asynchronously clear every E/M/W register, MdStartE and the counter to 0; StallMD then depends only on D (0); decode outputs remain combinational.
REQ-017 SHALL, on reset mid-mult/div, abandon the operation; first edge after release behaves as idle.

Verification
REQ-018 Reset: rst_n=0 mid-cycle with LW in flight -> all E/M/W outputs 0 immediately, counter 0.
REQ-019 Pipeline: LW at cycle 0 -> E cycle1 (RegWriteE=1, MemtoRegE=1, ALUSrcE=1, ALUControlE=010), M cycle2, W cycle3 (RegWriteW=1, MemtoRegW=1).
REQ-020 Decode sweep: R-type or (Funct 100101) -> RegDstE=1, ALUControlE=001; SUBI -> 110; BEQZ -> BranchD=1; SW -> MemWriteE=1; Op=111111 -> IllegalD=1, bundle 0.
REQ-021 Mult/div: mult then div back-to-back, MD_LATENCY=4 -> MdStartE pulse, StallMD=1 for 4 cycles, div enters E on the 5th edge with second MdStartE pulse.
REQ-022 Flush/stall: FlushE=1 with ADDI in D -> RegWriteE=0 next cycle; StallIn=1 with mult in D -> MdStartE=0, counter stays 0.
REQ-023 EN_MULDIV=0: Op=0, Funct=011000 -> IllegalD=1, MdStartE=0, StallMD=0.
